// File: rtl/piso_pkg.sv
// Shared types for the parallel-in/serial-out stage feeding the sequence detector.
// Pure declarations; no logic, no latency, no flow control.
// Imported by piso_serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of the bit counter; a 2-bit word still needs one counter bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Serializes WIDTH-bit words one bit per clock into the sequence detector's din.
// Latency: first bit registered on the accept edge; back-to-back words with no gap.
// Backpressure: load_ready only in IDLE or on the last-bit cycle; nothing buffered.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [CNT_W-1:0] bit_cnt, cnt_nxt;
    logic             dout_nxt, dout_valid_nxt, word_done_nxt;
    logic             last_bit, accept;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign last_bit   = (bit_cnt == LAST);
    assign load_ready = !reset && ((state == IDLE) || last_bit);
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_nxt      = state;
        shift_nxt      = shift_reg;
        cnt_nxt        = bit_cnt;
        dout_nxt       = dout;
        dout_valid_nxt = dout_valid;

        if (accept) begin
            // A load on the last-bit cycle chains the next word with zero gap.
            state_nxt      = SHIFT;
            shift_nxt      = data_in;
            cnt_nxt        = '0;
            dout_nxt       = out_bit(data_in);
            dout_valid_nxt = 1'b1;
        end else if (state == SHIFT) begin
            if (!last_bit) begin
                shift_nxt = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
                dout_nxt  = out_bit(shift_nxt);
                cnt_nxt   = bit_cnt + CNT_W'(1);
            end else begin
                state_nxt      = IDLE;
                dout_nxt       = IDLE_BIT;
                dout_valid_nxt = 1'b0;
            end
        end

        word_done_nxt = dout_valid_nxt && (cnt_nxt == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            bit_cnt    <= cnt_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            word_done  <= word_done_nxt;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first, LSB-first and IDLE_BIT=1 instances share one stimulus.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] data_in;

    logic lr_m, dout_m, dv_m, wd_m;
    logic lr_l, dout_l, dv_l, wd_l;
    logic lr_i, dout_i, dv_i, wd_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
        .load_ready(lr_m), .dout(dout_m), .dout_valid(dv_m), .word_done(wd_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
        .load_ready(lr_l), .dout(dout_l), .dout_valid(dv_l), .word_done(wd_l)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_idle1 (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
        .load_ready(lr_i), .dout(dout_i), .dout_valid(dv_i), .word_done(wd_i)
    );

    typedef struct {
        logic       rst;
        logic       lv;
        logic [7:0] d;
        logic       e_dout;
        logic       e_dv;
        logic       e_wd;
        logic       e_lr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic lv, input logic [7:0] d,
                                input logic e_dout, input logic e_dv, input logic e_wd,
                                input logic e_lr);
        vec_t v;
        v.rst = rst; v.lv = lv; v.d = d;
        v.e_dout = e_dout; v.e_dv = e_dv; v.e_wd = e_wd; v.e_lr = e_lr;
        tbl.push_back(v);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  word;
        logic [15:0] stream;
        int          nbits, nwords, gaps;
        logic        seen, acc, wd_at_accept2;

        reset = 1'b1; load_valid = 1'b1; data_in = 8'hFF;
        repeat (2) @(posedge clk);
        #1;

        // rst lv  data   dout dv wd lr
        add(1, 1, 8'hFF, 0, 0, 0, 0);   // valid during reset is ignored
        add(1, 1, 8'hFF, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 1, 8'hB4, 0, 0, 0, 1);   // accept B4
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 1, 1);   // last bit of B4
        add(0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 1, 8'hA5, 0, 0, 0, 1);   // accept A5
        add(0, 1, 8'h3C, 1, 1, 0, 0);   // 3C offered but not ready
        add(0, 1, 8'h3C, 0, 1, 0, 0);
        add(0, 1, 8'h3C, 1, 1, 0, 0);
        add(0, 1, 8'h3C, 0, 1, 0, 0);
        add(0, 1, 8'h3C, 0, 1, 0, 0);
        add(0, 1, 8'h3C, 1, 1, 0, 0);
        add(0, 1, 8'h3C, 0, 1, 0, 0);
        add(0, 1, 8'h3C, 1, 1, 1, 1);   // accept 3C on last bit of A5
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 1, 1);   // second word_done, 8 rows later
        add(0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 1, 8'hF0, 0, 0, 0, 1);   // accept F0
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(1, 1, 8'hFF, 1, 1, 0, 0);   // reset after 3 bits
        add(0, 1, 8'hC3, 0, 0, 0, 1);   // aborted; accept right after reset
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 1, 1);
        add(0, 0, 8'h00, 0, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            reset      = tbl[i].rst;
            load_valid = tbl[i].lv;
            data_in    = tbl[i].d;
            @(negedge clk);
            chk($sformatf("row%0d dout", i),       32'(dout_m), 32'(tbl[i].e_dout));
            chk($sformatf("row%0d dout_valid", i), 32'(dv_m),   32'(tbl[i].e_dv));
            chk($sformatf("row%0d word_done", i),  32'(wd_m),   32'(tbl[i].e_wd));
            chk($sformatf("row%0d load_ready", i), 32'(lr_m),   32'(tbl[i].e_lr));
            chk($sformatf("row%0d lsb dout_valid", i), 32'(dv_l), 32'(tbl[i].e_dv));
            chk($sformatf("row%0d lsb load_ready", i), 32'(lr_l), 32'(tbl[i].e_lr));
            if (!tbl[i].e_dv)
                chk($sformatf("row%0d idle1 dout", i), 32'(dout_i), 32'd1);
            @(posedge clk);
            #1;
        end

        // LSB-first: B4 must come out as 0,0,1,0,1,1,0,1.
        word = 8'hB4;
        reset = 1'b0; load_valid = 1'b1; data_in = word;
        @(posedge clk);
        #1;
        load_valid = 1'b0; data_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("lsb bit%0d dout", i), 32'(dout_l), 32'(word[i]));
            chk($sformatf("lsb bit%0d word_done", i), 32'(wd_l), (i == 7) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("lsb after word dout_valid", 32'(dv_l), 32'd0);
        @(posedge clk);
        #1;

        // Two words chained with valid held: stream must be contiguous 6D,B6.
        stream = '0; nbits = 0; nwords = 0; gaps = 0; seen = 1'b0; wd_at_accept2 = 1'b0;
        load_valid = 1'b1; data_in = 8'h6D;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            if (dv_m) begin
                stream = {stream[14:0], dout_m};
                nbits++;
                seen = 1'b1;
            end else if (seen && nbits < 16) begin
                gaps++;
            end
            acc = load_valid && lr_m;
            if (acc && nwords == 1) wd_at_accept2 = wd_m;
            @(posedge clk);
            #1;
            if (acc) begin
                nwords++;
                if (nwords == 1) data_in = 8'hB6;
                else begin
                    load_valid = 1'b0;
                    data_in = 8'h00;
                end
            end
        end
        chk("chain words accepted", 32'(nwords), 32'd2);
        chk("chain bit count", 32'(nbits), 32'd16);
        chk("chain stream", 32'(stream), 32'h6DB6);
        chk("chain gaps", 32'(gaps), 32'd0);
        chk("chain 2nd accept on last bit", 32'(wd_at_accept2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that sits directly upstream of the Mealy overlapping sequence detector and drives its `din`. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock. Back-to-back words are emitted with no gap, so the detector sees a continuous stream and can match overlapping patterns across word boundaries. A qualifier and an end-of-word pulse let downstream logic tell real data from idle fill.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range is 2..32.
- MSB_FIRST, 1, bit order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
- IDLE_BIT, 0, value driven on `dout` when no word is being sent.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word to serialize; sampled only on an accept edge.
- load_valid  input  1  upstream offers `data_in`.
- load_ready  output  1  block can take a word this cycle (combinational).
- dout  output  1  serial bit, registered; connects to the detector's `din`.
- dout_valid  output  1  high while `dout` carries a data bit, registered.
- word_done  output  1  one-cycle pulse, registered; high during the last bit of each word.

## Operation
- States (shared enum):
  - IDLE: no word loaded.
  - SHIFT: emitting bits.
- Accept: a word is taken on any edge where `load_valid && load_ready`.
- `load_ready` rules:
  - 0 while `reset` is high.
  - 1 in IDLE.
  - 1 in SHIFT only when `bit_cnt == WIDTH-1` (last-bit cycle).
  - 0 otherwise.
- On accept:
  - shift_reg loads `data_in`.
  - `dout` takes the first bit.
  - `dout_valid` goes to 1 and `bit_cnt` goes to 0.
  - State becomes SHIFT.
- In SHIFT, when `bit_cnt < WIDTH-1`: shift one position (toward the output end set by MSB_FIRST), `dout` takes the next bit, `bit_cnt` increments.
- In SHIFT, when `bit_cnt == WIDTH-1`:
  - With an accept: load the new word exactly as above. The next word follows with zero gap.
  - Without an accept: go to IDLE, `dout` becomes IDLE_BIT, `dout_valid` becomes 0.
- `word_done` is high exactly in cycles where `dout_valid && bit_cnt == WIDTH-1`.
- `bit_cnt` width is `$clog2(WIDTH)`. It never wraps past WIDTH-1; it is reloaded to 0 on accept.
- `data_in` and `load_valid` are ignored when `load_ready` is 0. No word is buffered beyond the one being shifted.

## Timing
- Reset values: `dout` = IDLE_BIT, `dout_valid` = 0, `word_done` = 0, state = IDLE, `bit_cnt` = 0, shift_reg = 0.
- Latency: for a word accepted at edge N, its first bit is on `dout` from edge N through edge N+1. Its last bit spans edge N+WIDTH-1 to N+WIDTH.
- Throughput: one bit per clock; one word per WIDTH clocks when `load_valid` is held high.
- Reset mid-word: the word is aborted at that edge. No partial bits appear after reset, and no new word is accepted while `reset` is high.
- `load_valid` high during reset: ignored. The first accept can happen on the first edge after `reset` falls.
- Idle `dout` stays constant at IDLE_BIT, so the detector sees no spurious transitions between words.

## Structure
- Package `piso_pkg`:
  - `state_t` enum {IDLE, SHIFT}.
  - Constant function for the counter width.
- Single module with no sub-module. Datapath (shift register, counter) and control (2-state FSM) live in one file.
- Top-level wiring: `piso_serializer.dout` connects to the detector's `din`. Both blocks share `clk` and `reset`.

## Test plan
- Reset with `load_valid` = 1 and `data_in` = 8'hFF -> no accept, `load_ready` = 0. After reset falls: `dout` = 0, `dout_valid` = 0.
- Single word 8'hB4, MSB_FIRST = 1 -> `dout` = 1,0,1,1,0,1,0,0 on 8 consecutive cycles, `word_done` high on the 8th, then `dout_valid` = 0.
- Same word with MSB_FIRST = 0 -> `dout` = 0,0,1,0,1,1,0,1.
- Back-to-back 8'hA5 then 8'h3C with `load_valid` held -> 16 contiguous valid bits, second accept on the last-bit cycle of the first word, two `word_done` pulses 8 cycles apart.
- Reset asserted after 3 bits of 8'hF0 -> next cycle `dout` = IDLE_BIT, `dout_valid` = 0. Remaining 5 bits are never emitted.
- Chained with the detector: feed 8'b0110_1101 then 8'b1011_0110 -> detector `dout` pulses match a software model of the 16-bit stream, including matches that straddle the word boundary.
